vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz VGA output on the Spartan-3E board. It divides the 50 MHz system clock down to the pixel rate and produces the column and row counters, the sync pulses, the video-active qualifier and the line/frame strobes. The colour/pattern control stage downstream consumes these outputs, and it must not keep its own row or column counters.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_PULSE, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel; must be ≥1
- SYNC_POL, 0, asserted level of both syncs (0 = active-low)

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- oPixelTick  out  1  one-cycle strobe; position outputs changed this cycle
- oCol  out  10  horizontal position, 0..H_TOTAL-1
- oRow  out  10  vertical position, 0..V_TOTAL-1
- oHorizontal_Sync  out  1  horizontal sync
- oVertical_Sync  out  1  vertical sync
- oVideoActive  out  1  high when oCol < H_VISIBLE and oRow < V_VISIBLE
- oLineStart  out  1  high with oPixelTick when oCol becomes 0
- oFrameStart  out  1  high with oPixelTick when (oCol,oRow) becomes (0,0)

Reset is Reset, synchronous, active-high; the clock is Clock.

## Operation
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024 so they fit the 10-bit counters. Unsized arithmetic is not permitted.
- Divider: counts 0..CLK_DIV-1 and wraps. A pixel advance occurs on the edge where it wraps. With CLK_DIV=1, every clock is an advance.
- Horizontal FSM: H_ACTIVE → H_FRONT → H_SYNC → H_BACK → H_ACTIVE.
  - Transitions happen on the advances where oCol moves to H_VISIBLE, H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_PULSE, and 0 respectively.
- Vertical FSM: V_ACTIVE → V_FRONT → V_SYNC → V_BACK, with the same boundaries on oRow. It steps only on advances where oCol wraps H_TOTAL-1 → 0.
- oCol increments on each advance and wraps H_TOTAL-1 → 0. On that wrap, oRow increments, and oRow wraps V_TOTAL-1 → 0.
- oHorizontal_Sync equals SYNC_POL in H_SYNC (oCol 656..751) and equals ~SYNC_POL otherwise.
- oVertical_Sync equals SYNC_POL in V_SYNC (oRow 490..491) and equals ~SYNC_POL otherwise. Its timing is aligned to pixel column 0 of the line.
- All outputs are registered and change only on advance edges, except oPixelTick, oLineStart and oFrameStart, which drop the next clock.
- Reset values: divider 0; oCol = H_TOTAL-1; oRow = V_TOTAL-1; both FSMs in their BACK states; both syncs at ~SYNC_POL; oVideoActive 0; all strobes 0.
- Reset asserted mid-frame forces the reset values on the next edge, with no partial line completed. Reset has priority over an advance on the same edge.

## Timing
- After the first edge with Reset low, the divider counts. The first advance is on the CLK_DIV-th such edge; it presents (0,0) with oPixelTick, oLineStart, oFrameStart and oVideoActive all 1.
- Latency from position change to the decoded outputs is 0. Sync, active and strobes are registered from the next-position value, so they are coherent with oCol/oRow in the same cycle.
- Line period = H_TOTAL × CLK_DIV clocks (1600). Frame period = 840000 clocks.
- oPixelTick is high for exactly 1 clock per pixel. It is permanently 1 when CLK_DIV=1.
- The downstream stage samples position, sync and active qualifiers only in oPixelTick cycles. It must not rely on values between ticks.

## Test plan
- Reset hold: assert Reset 5 cycles mid-frame → oCol=799, oRow=524, syncs=1, oVideoActive=0, strobes=0. Release → first oFrameStart exactly 2 clocks later with oCol=0, oRow=0.
- Line timing: measure across one line → oHorizontal_Sync low for 192 clocks starting when oCol=656; oVideoActive high for 1280 clocks; oLineStart spacing is 1600 clocks.
- Frame timing: run 2 frames → oVertical_Sync low exactly during rows 490–491 (3200 clocks); oFrameStart spacing is 840000 clocks; 307200 oPixelTick cycles with oVideoActive=1 per frame.
- Wrap boundary: at (799,524) the next tick gives (0,0) with oFrameStart=1. At (799,100) the next tick gives (0,101) with oLineStart=1 and oFrameStart=0.
- Simultaneous Reset and advance: assert Reset on a wrap edge → reset values win and no strobe is emitted.
- Parameter variant CLK_DIV=1, SYNC_POL=1 → oPixelTick constant 1; line period 800 clocks; oHorizontal_Sync high for 96 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480 VGA pixel timing: divider, column/row counters, syncs, strobes
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_PULSE   = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_PULSE   = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic       oPixelTick,
    output logic [9:0] oCol,
    output logic [9:0] oRow,
    output logic       oHorizontal_Sync,
    output logic       oVertical_Sync,
    output logic       oVideoActive,
    output logic       oLineStart,
    output logic       oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FRONT + H_PULSE);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FRONT + V_PULSE);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK} h_state_t;
    typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_col;
    logic [9:0]       r_row;
    h_state_t         r_h_state;
    v_state_t         r_v_state;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic             r_tick;
    logic             r_line;
    logic             r_frame;

    logic             w_advance;
    logic             w_col_wrap;
    logic [9:0]       w_col_next;
    logic [9:0]       w_row_next;
    h_state_t         w_h_state_next;
    v_state_t         w_v_state_next;

    assign w_advance  = (r_div == DIV_LAST);
    assign w_col_wrap = (r_col == H_LAST);
    assign w_col_next = w_col_wrap ? 10'd0 : r_col + 10'd1;
    assign w_row_next = !w_col_wrap ? r_row :
                        (r_row == V_LAST) ? 10'd0 : r_row + 10'd1;

    // Phase changes are decided from the position being entered, so the
    // decoded outputs registered alongside it line up with oCol/oRow.
    always_comb begin
        w_h_state_next = r_h_state;
        case (r_h_state)
            HS_ACTIVE: if (w_col_next == H_FP_START)   w_h_state_next = HS_FRONT;
            HS_FRONT:  if (w_col_next == H_SYNC_START) w_h_state_next = HS_SYNC;
            HS_SYNC:   if (w_col_next == H_BP_START)   w_h_state_next = HS_BACK;
            HS_BACK:   if (w_col_next == 10'd0)        w_h_state_next = HS_ACTIVE;
            default:                                   w_h_state_next = HS_BACK;
        endcase
    end

    always_comb begin
        w_v_state_next = r_v_state;
        if (w_col_wrap) begin
            case (r_v_state)
                VS_ACTIVE: if (w_row_next == V_FP_START)   w_v_state_next = VS_FRONT;
                VS_FRONT:  if (w_row_next == V_SYNC_START) w_v_state_next = VS_SYNC;
                VS_SYNC:   if (w_row_next == V_BP_START)   w_v_state_next = VS_BACK;
                VS_BACK:   if (w_row_next == 10'd0)        w_v_state_next = VS_ACTIVE;
                default:                                   w_v_state_next = VS_BACK;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_div     <= '0;
            r_col     <= H_LAST;
            r_row     <= V_LAST;
            r_h_state <= HS_BACK;
            r_v_state <= VS_BACK;
            r_hsync   <= ~SYNC_POL;
            r_vsync   <= ~SYNC_POL;
            r_active  <= 1'b0;
            r_tick    <= 1'b0;
            r_line    <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_tick  <= w_advance;
            r_line  <= w_advance && (w_col_next == 10'd0);
            r_frame <= w_advance && (w_col_next == 10'd0) && (w_row_next == 10'd0);
            if (w_advance) begin
                r_div     <= '0;
                r_col     <= w_col_next;
                r_row     <= w_row_next;
                r_h_state <= w_h_state_next;
                r_v_state <= w_v_state_next;
                r_hsync   <= (w_h_state_next == HS_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_vsync   <= (w_v_state_next == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_active  <= (w_h_state_next == HS_ACTIVE) && (w_v_state_next == VS_ACTIVE);
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign oPixelTick       = r_tick;
    assign oCol             = r_col;
    assign oRow             = r_row;
    assign oHorizontal_Sync = r_hsync;
    assign oVertical_Sync   = r_vsync;
    assign oVideoActive     = r_active;
    assign oLineStart       = r_line;
    assign oFrameStart      = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset bench with arithmetic position model for vga_timing_gen
module tb_vga_timing_gen;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    bit chk_en = 1'b0;

    logic       a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
    logic [9:0] a_col, a_row;
    logic       b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_col, b_row;
    logic       c_tick, c_hs, c_vs, c_act, c_ls, c_fs;
    logic [9:0] c_col, c_row;

    // A: small geometry, divide by 3, active-low syncs
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(3), .H_PULSE(5), .H_BACK(4),
        .V_VISIBLE(6),  .V_FRONT(2), .V_PULSE(2), .V_BACK(3),
        .CLK_DIV(3), .SYNC_POL(1'b0)
    ) u_dut_a (
        .Clock(Clock), .Reset(Reset), .oPixelTick(a_tick), .oCol(a_col), .oRow(a_row),
        .oHorizontal_Sync(a_hs), .oVertical_Sync(a_vs), .oVideoActive(a_act),
        .oLineStart(a_ls), .oFrameStart(a_fs)
    );

    // B: default geometry, no division, active-high syncs
    vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_dut_b (
        .Clock(Clock), .Reset(Reset), .oPixelTick(b_tick), .oCol(b_col), .oRow(b_row),
        .oHorizontal_Sync(b_hs), .oVertical_Sync(b_vs), .oVideoActive(b_act),
        .oLineStart(b_ls), .oFrameStart(b_fs)
    );

    // C: all defaults
    vga_timing_gen u_dut_c (
        .Clock(Clock), .Reset(Reset), .oPixelTick(c_tick), .oCol(c_col), .oRow(c_row),
        .oHorizontal_Sync(c_hs), .oVertical_Sync(c_vs), .oVideoActive(c_act),
        .oLineStart(c_ls), .oFrameStart(c_fs)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the number of un-reset edges: pixel p = edges / div,
    // pixel 1 is (0,0), pixel 0 is the reset position (last col, last row).
    function automatic logic [25:0] ref_out(input int ec, input int div,
                                            input int hv, input int hf, input int hp, input int hb,
                                            input int vv, input int vf, input int vp, input int vb,
                                            input bit pol);
        int ht, vt, p, col, row;
        logic tick, hs, vs, act, ls, fs;
        logic [9:0] c10, r10;
        ht = hv + hf + hp + hb;
        vt = vv + vf + vp + vb;
        p  = ec / div;
        tick = (ec > 0) && (ec % div == 0);
        if (p == 0) begin
            col = ht - 1;
            row = vt - 1;
        end else begin
            col = (p - 1) % ht;
            row = ((p - 1) / ht) % vt;
        end
        hs  = (col >= hv + hf && col < hv + hf + hp) ? pol : ~pol;
        vs  = (row >= vv + vf && row < vv + vf + vp) ? pol : ~pol;
        act = (col < hv) && (row < vv);
        ls  = tick && (col == 0);
        fs  = ls && (row == 0);
        c10 = col[9:0];
        r10 = row[9:0];
        return {tick, c10, r10, hs, vs, act, ls, fs};
    endfunction

    always @(posedge Clock) e <= Reset ? 0 : e + 1;

    always @(negedge Clock) begin
        if (chk_en) begin
            check_val("cyc_a", 32'({a_tick, a_col, a_row, a_hs, a_vs, a_act, a_ls, a_fs}),
                      32'(ref_out(e, 3, 16, 3, 5, 4, 6, 2, 2, 3, 1'b0)));
            check_val("cyc_b", 32'({b_tick, b_col, b_row, b_hs, b_vs, b_act, b_ls, b_fs}),
                      32'(ref_out(e, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1)));
            check_val("cyc_c", 32'({c_tick, c_col, c_row, c_hs, c_vs, c_act, c_ls, c_fs}),
                      32'(ref_out(e, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
        end
    end

    initial begin
        int n, cnt_hs, cnt_act, first_ls, hs_col, cnt_tick, cnt_vs, cnt_at;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk_en = 1'b1;
        Reset  = 1'b0;
        repeat (700) @(negedge Clock);

        Reset = 1'b1;
        repeat (5) @(negedge Clock);
        check_val("rst_hold_c", 32'({c_col, c_row, c_hs, c_vs, c_act, c_tick, c_ls, c_fs}),
                  32'({10'd799, 10'd524, 6'b110000}));
        check_val("rst_hold_a", 32'({a_col, a_row, a_tick}), 32'({10'd27, 10'd12, 1'b0}));
        Reset = 1'b0;
        n = 0;
        do begin @(negedge Clock); n++; end while (!c_fs && n < 10);
        check_val("first_fs_latency", 32'(n), 32'd2);
        check_val("first_fs_pos", 32'({c_col, c_row, c_tick, c_ls, c_act}), 32'({20'd0, 3'b111}));

        cnt_hs = 0; cnt_act = 0; first_ls = 0; hs_col = -1;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge Clock);
            if (!c_hs) begin
                cnt_hs++;
                if (hs_col < 0) hs_col = int'(c_col);
            end
            if (c_act) cnt_act++;
            if (c_ls && first_ls == 0) first_ls = i;
        end
        check_val("c_hsync_low_clks", 32'(cnt_hs), 32'd192);
        check_val("c_hsync_first_col", 32'(hs_col), 32'd656);
        check_val("c_active_clks", 32'(cnt_act), 32'd1280);
        check_val("c_line_period", 32'(first_ls), 32'd1600);

        n = 0;
        do begin @(negedge Clock); n++; end while (!b_ls && n < 1000);
        check_val("b_ls_wait", 32'(b_ls), 32'd1);
        cnt_tick = 0; cnt_hs = 0; first_ls = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge Clock);
            if (b_tick) cnt_tick++;
            if (b_hs) cnt_hs++;
            if (b_ls && first_ls == 0) first_ls = i;
        end
        check_val("b_tick_clks", 32'(cnt_tick), 32'd800);
        check_val("b_hsync_high_clks", 32'(cnt_hs), 32'd96);
        check_val("b_line_period", 32'(first_ls), 32'd800);

        n = 0;
        do begin @(negedge Clock); n++; end while (!a_fs && n < 1200);
        check_val("a_fs_wait", 32'(a_fs), 32'd1);
        for (int f = 0; f < 2; f++) begin
            cnt_vs = 0; cnt_at = 0; first_ls = 0;
            for (int i = 1; i <= 1092; i++) begin
                @(negedge Clock);
                if (!a_vs) cnt_vs++;
                if (a_tick && a_act) cnt_at++;
                if (a_fs && first_ls == 0) first_ls = i;
            end
            check_val("a_frame_period", 32'(first_ls), 32'd1092);
            check_val("a_vsync_low_clks", 32'(cnt_vs), 32'd168);
            check_val("a_active_ticks", 32'(cnt_at), 32'd96);
        end

        n = 0;
        do begin @(negedge Clock); n++; end
        while (!(a_tick && a_col == 10'd27 && a_row == 10'd12) && n < 1200);
        check_val("a_last_pixel_wait", 32'({a_tick, a_col, a_row}), 32'({1'b1, 10'd27, 10'd12}));
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check_val("a_reset_beats_wrap", 32'({a_tick, a_ls, a_fs, a_col, a_row}),
                  32'({3'b000, 10'd27, 10'd12}));
        Reset = 1'b0;

        for (int k = 0; k < 20000; k++) begin
            @(negedge Clock);
            if ($urandom_range(0, 1499) == 0) begin
                Reset = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge Clock);
                Reset = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
